// File: rtl/adaptive_max_pool1d_stream.sv
// Streaming 1-D adaptive max pool: splits each row of N_IN signed elements into
// N_OUT equal windows and emits the window maxima P_OUT at a time.
module adaptive_max_pool1d_stream #(
  parameter int DATA_IN_0_PRECISION_0        = 8,
  parameter int DATA_IN_0_PRECISION_1        = 3,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_0  = 8,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_1  = 2,
  parameter int DATA_IN_0_PARALLELISM_DIM_0  = 2,
  parameter int DATA_OUT_0_PRECISION_0       = 8,
  parameter int DATA_OUT_0_PRECISION_1       = 3,
  parameter int DATA_OUT_0_TENSOR_SIZE_DIM_0 = 2,
  parameter int DATA_OUT_0_PARALLELISM_DIM_0 = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [DATA_IN_0_PARALLELISM_DIM_0],
  input  logic                              data_in_0_valid,
  output logic                              data_in_0_ready,
  output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [DATA_OUT_0_PARALLELISM_DIM_0],
  output logic                              data_out_0_valid,
  input  logic                              data_out_0_ready
);

  localparam int unsigned W     = DATA_IN_0_PRECISION_0;
  localparam int unsigned N_IN  = DATA_IN_0_TENSOR_SIZE_DIM_0;
  localparam int unsigned ROWS  = DATA_IN_0_TENSOR_SIZE_DIM_1;
  localparam int unsigned P_IN  = DATA_IN_0_PARALLELISM_DIM_0;
  localparam int unsigned N_OUT = DATA_OUT_0_TENSOR_SIZE_DIM_0;
  localparam int unsigned P_OUT = DATA_OUT_0_PARALLELISM_DIM_0;
  localparam int unsigned K     = N_IN / N_OUT;
  localparam int unsigned BPW   = K / P_IN;
  localparam int unsigned WPB   = P_OUT;
  localparam int unsigned OBPR  = N_OUT / P_OUT;

  localparam int unsigned BCW = (BPW  > 1) ? $clog2(BPW)  : 1;
  localparam int unsigned WCW = (WPB  > 1) ? $clog2(WPB)  : 1;
  localparam int unsigned OCW = (OBPR > 1) ? $clog2(OBPR) : 1;
  localparam int unsigned RCW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [BCW-1:0] BEAT_LAST = BCW'(BPW - 1);
  localparam logic [WCW-1:0] WIN_LAST  = WCW'(WPB - 1);
  localparam logic [OCW-1:0] OUT_LAST  = OCW'(OBPR - 1);
  localparam logic [RCW-1:0] ROW_LAST  = RCW'(ROWS - 1);

  if ((N_IN % N_OUT) != 0 || (K % P_IN) != 0 || (N_OUT % P_OUT) != 0 ||
      DATA_IN_0_PRECISION_0 != DATA_OUT_0_PRECISION_0 ||
      DATA_IN_0_PRECISION_1 != DATA_OUT_0_PRECISION_1) begin : g_bad_params
    $error("adaptive_max_pool1d_stream: inconsistent size/precision parameters");
  end

  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   gather_q [WPB];
  logic [W-1:0]   gather_d [WPB];
  logic [W-1:0]   out_q    [P_OUT];
  logic [W-1:0]   out_d    [P_OUT];
  logic           valid_q, valid_d;
  logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
  logic [WCW-1:0] win_cnt_q, win_cnt_d;
  logic [OCW-1:0] out_cnt_q, out_cnt_d;
  logic [RCW-1:0] row_cnt_q, row_cnt_d;

  logic [W-1:0] beat_max;
  logic [W-1:0] win_max;
  logic         accept;
  logic         win_done;
  logic         load;

  assign data_in_0_ready  = !(valid_q && !data_out_0_ready);
  assign accept           = data_in_0_valid && data_in_0_ready;
  assign win_done         = accept && (beat_cnt_q == BEAT_LAST);
  assign load             = win_done && (win_cnt_q == WIN_LAST);
  assign data_out_0       = out_q;
  assign data_out_0_valid = valid_q;

  always_comb begin
    beat_max = data_in_0[0];
    for (int unsigned j = 1; j < P_IN; j++) begin
      if ($signed(data_in_0[j]) > $signed(beat_max)) beat_max = data_in_0[j];
    end
    // The first beat of a window starts fresh so the running max never leaks across windows.
    if (beat_cnt_q == '0 || $signed(beat_max) > $signed(acc_q)) win_max = beat_max;
    else                                                       win_max = acc_q;
  end

  always_comb begin
    acc_d      = acc_q;
    gather_d   = gather_q;
    out_d      = out_q;
    valid_d    = valid_q;
    beat_cnt_d = beat_cnt_q;
    win_cnt_d  = win_cnt_q;
    out_cnt_d  = out_cnt_q;
    row_cnt_d  = row_cnt_q;

    if (accept) begin
      acc_d      = win_max;
      beat_cnt_d = (beat_cnt_q == BEAT_LAST) ? '0 : beat_cnt_q + BCW'(1);
    end

    if (win_done) begin
      gather_d[win_cnt_q] = win_max;
      win_cnt_d = (win_cnt_q == WIN_LAST) ? '0 : win_cnt_q + WCW'(1);
    end

    if (data_out_0_ready) valid_d = 1'b0;

    // The last slot bypasses the gather register so the beat leaves one edge after its final accept.
    if (load) begin
      for (int unsigned w = 0; w < WPB; w++) begin
        out_d[w] = (w == WPB - 1) ? win_max : gather_q[w];
      end
      valid_d   = 1'b1;
      out_cnt_d = (out_cnt_q == OUT_LAST) ? '0 : out_cnt_q + OCW'(1);
      if (out_cnt_q == OUT_LAST) begin
        row_cnt_d = (row_cnt_q == ROW_LAST) ? '0 : row_cnt_q + RCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      gather_q   <= '{default: '0};
      out_q      <= '{default: '0};
      valid_q    <= 1'b0;
      beat_cnt_q <= '0;
      win_cnt_q  <= '0;
      out_cnt_q  <= '0;
      row_cnt_q  <= '0;
    end else begin
      acc_q      <= acc_d;
      gather_q   <= gather_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      beat_cnt_q <= beat_cnt_d;
      win_cnt_q  <= win_cnt_d;
      out_cnt_q  <= out_cnt_d;
      row_cnt_q  <= row_cnt_d;
    end
  end

endmodule
